// File: rtl/gp_lut_pkg.sv
// gp_lut_pkg: shared definitions for the GP LUT bank.
//   cfg_sel_e   : CFG_SEL encodings (2-LUT, 3-LUT, 4-LUT, none)
//   LUT*_WIDTH  : truth-table widths of the three LUTs
package gp_lut_pkg;

   typedef enum logic [1:0] {
      SEL_LUT2 = 2'd0,
      SEL_LUT3 = 2'd1,
      SEL_LUT4 = 2'd2,
      SEL_NONE = 2'd3
   } cfg_sel_e;

   localparam int unsigned LUT2_WIDTH = 4;
   localparam int unsigned LUT3_WIDTH = 8;
   localparam int unsigned LUT4_WIDTH = 16;
   localparam int unsigned CFG_WIDTH  = LUT4_WIDTH;

endpackage

// File: rtl/gp_lut_core.sv
// gp_lut_core: one N-input look-up table with a writable truth table.
//   clk      : clock, table updates on rising edge
//   rst      : synchronous active-high reset, reloads INIT (wins over we)
//   we       : load wdata into the table at the next edge
//   wdata    : new truth table (2^N bits)
//   lut_in   : LUT inputs, lut_in[0] is the index LSB
//   lut_out  : table[lut_in], combinational
//   tbl      : current truth table
module gp_lut_core #(
   parameter int unsigned           N    = 2,
   parameter logic [(1<<N)-1:0]     INIT = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [(1<<N)-1:0]   wdata,
   input  logic [N-1:0]        lut_in,
   output logic                lut_out,
   output logic [(1<<N)-1:0]   tbl
);

   logic [(1<<N)-1:0] tbl_d;
   logic [(1<<N)-1:0] tbl_q;

   always_comb begin
      tbl_d = tbl_q;
      if (rst) begin
         tbl_d = INIT;
      end else if (we) begin
         tbl_d = wdata;
      end
   end

   always_ff @(posedge clk) begin
      tbl_q <= tbl_d;
   end

   assign lut_out = tbl_q[lut_in];
   assign tbl     = tbl_q;

endmodule

// File: rtl/gp_lut_bank.sv
// gp_lut_bank: bank of three configurable LUTs (2-, 3- and 4-input).
//   CLK, RST        : clock and synchronous active-high reset (reloads INIT*)
//   CFG_WE/SEL/DATA : truth-table write port; SEL 0/1/2 = 2/3/4-LUT, 3 = none
//   CFG_RDATA       : table of the LUT chosen by CFG_SEL, zero-extended
//   IN2_*, IN3_*, IN4_* : LUT inputs, suffix 0 is the index LSB
//   OUT2, OUT3, OUT4    : combinational LUT outputs
module gp_lut_bank
   import gp_lut_pkg::*;
#(
   parameter logic [LUT2_WIDTH-1:0] INIT2 = 4'h0,
   parameter logic [LUT3_WIDTH-1:0] INIT3 = 8'h00,
   parameter logic [LUT4_WIDTH-1:0] INIT4 = 16'h0000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CFG_WE,
   input  logic [1:0]           CFG_SEL,
   input  logic [CFG_WIDTH-1:0] CFG_DATA,
   output logic [CFG_WIDTH-1:0] CFG_RDATA,
   input  logic                 IN2_0,
   input  logic                 IN2_1,
   input  logic                 IN3_0,
   input  logic                 IN3_1,
   input  logic                 IN3_2,
   input  logic                 IN4_0,
   input  logic                 IN4_1,
   input  logic                 IN4_2,
   input  logic                 IN4_3,
   output logic                 OUT2,
   output logic                 OUT3,
   output logic                 OUT4
);

   cfg_sel_e                sel;
   logic                    we2, we3, we4;
   logic [LUT2_WIDTH-1:0]   tbl2;
   logic [LUT3_WIDTH-1:0]   tbl3;
   logic [LUT4_WIDTH-1:0]   tbl4;

   assign sel = cfg_sel_e'(CFG_SEL);

   always_comb begin
      we2 = 1'b0;
      we3 = 1'b0;
      we4 = 1'b0;
      if (CFG_WE) begin
         case (sel)
            SEL_LUT2: we2 = 1'b1;
            SEL_LUT3: we3 = 1'b1;
            SEL_LUT4: we4 = 1'b1;
            default:  ;
         endcase
      end
   end

   gp_lut_core #(.N(2), .INIT(INIT2)) u_lut2 (
      .clk     (CLK),
      .rst     (RST),
      .we      (we2),
      .wdata   (CFG_DATA[LUT2_WIDTH-1:0]),
      .lut_in  ({IN2_1, IN2_0}),
      .lut_out (OUT2),
      .tbl     (tbl2)
   );

   gp_lut_core #(.N(3), .INIT(INIT3)) u_lut3 (
      .clk     (CLK),
      .rst     (RST),
      .we      (we3),
      .wdata   (CFG_DATA[LUT3_WIDTH-1:0]),
      .lut_in  ({IN3_2, IN3_1, IN3_0}),
      .lut_out (OUT3),
      .tbl     (tbl3)
   );

   gp_lut_core #(.N(4), .INIT(INIT4)) u_lut4 (
      .clk     (CLK),
      .rst     (RST),
      .we      (we4),
      .wdata   (CFG_DATA),
      .lut_in  ({IN4_3, IN4_2, IN4_1, IN4_0}),
      .lut_out (OUT4),
      .tbl     (tbl4)
   );

   always_comb begin
      CFG_RDATA = '0;
      case (sel)
         SEL_LUT2: CFG_RDATA = {{(CFG_WIDTH-LUT2_WIDTH){1'b0}}, tbl2};
         SEL_LUT3: CFG_RDATA = {{(CFG_WIDTH-LUT3_WIDTH){1'b0}}, tbl3};
         SEL_LUT4: CFG_RDATA = tbl4;
         default:  CFG_RDATA = '0;
      endcase
   end

endmodule

// File: tb/tb_gp_lut_bank.sv
// tb_gp_lut_bank: directed checks of gp_lut_bank with INIT2 = XOR,
// INIT3 = 3-input parity, INIT4 = 4-input AND.
module tb_gp_lut_bank;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [15:0] cfg_data;
   logic [15:0] cfg_rdata;
   logic [1:0]  in2;
   logic [2:0]  in3;
   logic [3:0]  in4;
   logic        out2, out3, out4;

   int unsigned n_vec;
   int unsigned n_err;

   gp_lut_bank #(
      .INIT2 (4'b0110),
      .INIT3 (8'h96),
      .INIT4 (16'h8000)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .CFG_WE    (cfg_we),
      .CFG_SEL   (cfg_sel),
      .CFG_DATA  (cfg_data),
      .CFG_RDATA (cfg_rdata),
      .IN2_0     (in2[0]),
      .IN2_1     (in2[1]),
      .IN3_0     (in3[0]),
      .IN3_1     (in3[1]),
      .IN3_2     (in3[2]),
      .IN4_0     (in4[0]),
      .IN4_1     (in4[1]),
      .IN4_2     (in4[2]),
      .IN4_3     (in4[3]),
      .OUT2      (out2),
      .OUT3      (out3),
      .OUT4      (out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_data = data;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
      cfg_data = '0;
   endtask

   task automatic read_tbl(input string tag, input logic [1:0] sel, input logic [15:0] exp);
      cfg_sel = sel;
      #1;
      chk(tag, cfg_rdata, exp);
   endtask

   task automatic sweep_parity3(input string tag);
      for (int i = 0; i < 8; i++) begin
         in3 = 3'(i);
         #1;
         chk(tag, {15'd0, out3}, {15'd0, ^in3});
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_sel  = 2'd3;
      cfg_data = '0;
      in2      = '0;
      in3      = '0;
      in4      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      read_tbl("rst_tbl2", 2'd0, 16'h0006);
      read_tbl("rst_tbl3", 2'd1, 16'h0096);
      read_tbl("rst_tbl4", 2'd2, 16'h8000);
      read_tbl("rst_none", 2'd3, 16'h0000);

      // 2-LUT XOR sweep, zero latency
      for (int i = 0; i < 4; i++) begin
         in2 = 2'(i);
         #1;
         chk("xor2", {15'd0, out2}, {15'd0, in2[0] ^ in2[1]});
      end

      // 4-LUT AND sweep
      for (int i = 0; i < 16; i++) begin
         in4 = 4'(i);
         #1;
         chk("and4", {15'd0, out4}, (i == 15) ? 16'd1 : 16'd0);
      end

      sweep_parity3("par3_init");

      // 3-LUT rewrite to majority
      in2 = 2'b01;
      in4 = 4'b1111;
      cfg_write(2'd1, 16'h00E8);
      read_tbl("wr3_tbl3", 2'd1, 16'h00E8);
      read_tbl("wr3_tbl2", 2'd0, 16'h0006);
      read_tbl("wr3_tbl4", 2'd2, 16'h8000);
      chk("wr3_out2", {15'd0, out2}, 16'd1);
      chk("wr3_out4", {15'd0, out4}, 16'd1);
      for (int i = 0; i < 8; i++) begin
         in3 = 3'(i);
         #1;
         chk("maj3", {15'd0, out3},
             {15'd0, (in3[0] & in3[1]) | (in3[0] & in3[2]) | (in3[1] & in3[2])});
      end

      // reset beats simultaneous write, restores earlier-written 3-LUT too
      @(negedge clk);
      rst      = 1'b1;
      cfg_we   = 1'b1;
      cfg_sel  = 2'd2;
      cfg_data = 16'hFFFF;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cfg_we   = 1'b0;
      cfg_data = '0;
      read_tbl("rstwr_tbl4", 2'd2, 16'h8000);
      read_tbl("rstwr_tbl3", 2'd1, 16'h0096);
      sweep_parity3("par3_restored");

      // write to SEL_NONE changes nothing
      cfg_write(2'd3, 16'hFFFF);
      read_tbl("none_rdata", 2'd3, 16'h0000);
      read_tbl("none_tbl2", 2'd0, 16'h0006);
      read_tbl("none_tbl3", 2'd1, 16'h0096);
      read_tbl("none_tbl4", 2'd2, 16'h8000);

      // 1-input inverter on the 2-LUT; upper CFG_DATA bits must be ignored
      cfg_write(2'd0, 16'hABC1);
      read_tbl("inv_tbl2", 2'd0, 16'h0001);
      read_tbl("inv_tbl4", 2'd2, 16'h8000);
      in2 = 2'b00;
      #1;
      chk("inv_in0", {15'd0, out2}, 16'd1);
      in2 = 2'b01;
      #1;
      chk("inv_in1", {15'd0, out2}, 16'd0);

      // 4-LUT full-width write
      cfg_write(2'd2, 16'h0001);
      read_tbl("wr4_tbl4", 2'd2, 16'h0001);
      in4 = 4'b0000;
      #1;
      chk("wr4_out0", {15'd0, out4}, 16'd1);
      in4 = 4'b1111;
      #1;
      chk("wr4_out15", {15'd0, out4}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
